operand_bypass: RTL and testbench
=================================

// Module: operand_bypass
// PURPOSE
//   Execute-side operand stage directly downstream of the register file read port.
//   - Captures the rs1/rs2 addresses issued to the register file; realigns them with the registered read data one cycle later.
//   - Replaces stale read data with in-flight results (MEM result, pending WB write, WB writes during a stall).
//   - Raises a load-use stall when an operand depends on a load whose data is not yet returned.
// PARAMETERS
//   XLEN        64  operand/result width
//   REG_ADDR_W  9   register address width (matches register file port)
// PORTS
//   clk              in   1           rising-edge clock
//   rst_n            in   1           asynchronous active-low reset
//   stall_in         in   1           pipeline stall (same net as register file stall_in)
//   id_valid_in      in   1           decode presents a valid instruction this cycle
//   rs1_in           in   REG_ADDR_W  rs1 address issued to register file this cycle
//   rs2_in           in   REG_ADDR_W  rs2 address issued to register file this cycle
//   rf_rs1_value_in  in   XLEN        register file rs1_value_out
//   rf_rs2_value_in  in   XLEN        register file rs2_value_out
//   mem_write_in     in   1           instruction one ahead (MEM) writes a register
//   mem_rd_in        in   REG_ADDR_W  MEM destination
//   mem_value_in     in   XLEN        MEM result
//   mem_load_in      in   1           MEM instruction is a load
//   mem_ready_in     in   1           load data valid on mem_value_in
//   wb_write_in      in   1           register file write enable (same net as rd_write_in)
//   wb_rd_in         in   REG_ADDR_W  register file write address
//   wb_value_in      in   XLEN        register file write data
//   rs1_value_out    out  XLEN        forwarded rs1 operand
//   rs2_value_out    out  XLEN        forwarded rs2 operand
//   operands_valid_out out 1          operands valid and hazard-free this cycle
//   hazard_stall_out out  1           load-use stall request to pipeline control
// BEHAVIOUR
//   - Reset (async, rst_n=0): rs1_q=rs2_q=0, valid_q=0, ovr_valid=0, ovr_value=0.
//     Outputs during/after reset: values 0, operands_valid_out=0, hazard_stall_out=0.
//   - Edge with !stall_in: rsN_q<=rsN_in, valid_q<=id_valid_in.
//     ovrN_valid<=(wb_write_in && wb_rd_in==rsN_in && rsN_in!=0); ovrN_value<=wb_value_in on match.
//   - Edge with stall_in: rsN_q, valid_q held.
//     If wb_write_in && wb_rd_in==rsN_q && rsN_q!=0 -> ovrN_valid<=1, ovrN_value<=wb_value_in.
//     Otherwise override held.
//   - Output mux per operand (combinational, zero latency from rsN_q), highest priority first:
//     1. rsN_q==0 -> 0
//     2. mem_write_in && mem_rd_in==rsN_q -> mem_value_in (mem_ready_in ignored here; hazard covers it)
//     3. wb_write_in && wb_rd_in==rsN_q -> wb_value_in
//     4. ovrN_valid -> ovrN_value
//     5. else rf_rsN_value_in
//   - hazard_stall_out = valid_q && mem_write_in && mem_load_in && !mem_ready_in
//     && ((mem_rd_in==rs1_q && rs1_q!=0) || (mem_rd_in==rs2_q && rs2_q!=0)).
//   - operands_valid_out = valid_q && !hazard_stall_out.
//   - Writes to register 0 are never forwarded or captured (mirrors register file write guard).
//   - MEM and WB both match the same register: MEM wins (younger).
//   - Override is cleared on the next non-stalled edge unless a new WB match occurs at that edge.
//   - Reset mid-stall clears all state; the first post-reset valid instruction needs a non-stalled edge.
//   - Arithmetic: equality compares on full REG_ADDR_W; no width conversion of values.
// STRUCTURE
//   - Shared package riscy_pkg: XLEN, REG_ADDR_W, REG_ZERO constant, fwd_src_t enum {ZERO,MEM,WB,OVR,RF}.
//   - Sub-module bypass_lane (one per operand, instantiated twice):
//     address register, override register, priority mux, per-lane load-match flag.
//   - Top level: valid_q, hazard OR-reduction, output ports.
// TESTING
//   - Reset: rst_n=0 mid-operation with valid_q=1 -> outputs 0, operands_valid_out=0 immediately (async).
//   - Same-edge WB: issue rs1=5, wb writes x5=0xAA at the same edge, rf returns stale 0x11
//     -> next cycle rs1_value_out=0xAA.
//   - MEM priority: rs2_q=7, mem writes x7=0x22, wb writes x7=0x33 -> rs2_value_out=0x22.
//   - Stall capture: rs1_q=3, stall_in=1 for 3 cycles, wb writes x3=0x44 in cycle 2
//     -> rs1_value_out=0x44 from cycle 3 until next unstalled edge.
//   - Load-use: rs1_q=9, mem load to x9, mem_ready_in=0 for 2 cycles
//     -> hazard_stall_out=1, operands_valid_out=0 for 2 cycles.
//     Then ready=1, mem_value_in=0x55 -> rs1_value_out=0x55, operands_valid_out=1.
//   - x0: rs1_in=0, wb writes x0=0xFF -> rs1_value_out=0; no override set.

Source files
------------

// File: rtl/riscy_pkg.sv
// riscy_pkg: shared widths, the zero-register constant and forwarding source encoding
package riscy_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 9;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef enum logic [2:0] {FWD_ZERO, FWD_MEM, FWD_WB, FWD_OVR, FWD_RF} fwd_src_t;
endpackage

// File: rtl/operand_bypass_if.sv
// operand_bypass_if: decode/register-file/MEM/WB inputs and forwarded operand outputs
interface operand_bypass_if;
  import riscy_pkg::*;
  logic                  stall_in;
  logic                  id_valid_in;
  logic [REG_ADDR_W-1:0] rs1_in;
  logic [REG_ADDR_W-1:0] rs2_in;
  logic [XLEN-1:0]       rf_rs1_value_in;
  logic [XLEN-1:0]       rf_rs2_value_in;
  logic                  mem_write_in;
  logic [REG_ADDR_W-1:0] mem_rd_in;
  logic [XLEN-1:0]       mem_value_in;
  logic                  mem_load_in;
  logic                  mem_ready_in;
  logic                  wb_write_in;
  logic [REG_ADDR_W-1:0] wb_rd_in;
  logic [XLEN-1:0]       wb_value_in;
  logic [XLEN-1:0]       rs1_value_out;
  logic [XLEN-1:0]       rs2_value_out;
  logic                  operands_valid_out;
  logic                  hazard_stall_out;
  modport master (
    output stall_in, id_valid_in, rs1_in, rs2_in, rf_rs1_value_in, rf_rs2_value_in,
           mem_write_in, mem_rd_in, mem_value_in, mem_load_in, mem_ready_in,
           wb_write_in, wb_rd_in, wb_value_in,
    input  rs1_value_out, rs2_value_out, operands_valid_out, hazard_stall_out
  );
  modport slave (
    input  stall_in, id_valid_in, rs1_in, rs2_in, rf_rs1_value_in, rf_rs2_value_in,
           mem_write_in, mem_rd_in, mem_value_in, mem_load_in, mem_ready_in,
           wb_write_in, wb_rd_in, wb_value_in,
    output rs1_value_out, rs2_value_out, operands_valid_out, hazard_stall_out
  );
endinterface

// File: rtl/bypass_lane.sv
// bypass_lane: one operand's address register, WB override capture, priority mux and load-match flag
module bypass_lane
  import riscy_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [XLEN-1:0]       rf_value_in,
  input  logic                  mem_write_in,
  input  logic [REG_ADDR_W-1:0] mem_rd_in,
  input  logic [XLEN-1:0]       mem_value_in,
  input  logic                  mem_load_in,
  input  logic                  wb_write_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_in,
  input  logic [XLEN-1:0]       wb_value_in,
  output logic [XLEN-1:0]       value_out,
  output logic                  load_match_out
);
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic                  ovr_valid_q, ovr_valid_d;
  logic [XLEN-1:0]       ovr_value_q, ovr_value_d;
  logic                  wb_cap, mem_hit, wb_hit;
  fwd_src_t              src;
  // the override tracks the address that will be held after this edge: new on issue, old on stall
  always_comb begin
    rs_d           = stall_in ? rs_q : rs_in;
    wb_cap         = wb_write_in && wb_rd_in == rs_d && rs_d != REG_ZERO;
    ovr_valid_d    = wb_cap || (stall_in && ovr_valid_q);
    ovr_value_d    = wb_cap ? wb_value_in : ovr_value_q;
    mem_hit        = mem_write_in && mem_rd_in == rs_q;
    wb_hit         = wb_write_in && wb_rd_in == rs_q;
    load_match_out = mem_hit && mem_load_in && rs_q != REG_ZERO;
    src            = rs_q == REG_ZERO ? FWD_ZERO :
                     mem_hit          ? FWD_MEM  :
                     wb_hit           ? FWD_WB   :
                     ovr_valid_q      ? FWD_OVR  : FWD_RF;
    value_out      = src == FWD_ZERO ? '0           :
                     src == FWD_MEM  ? mem_value_in :
                     src == FWD_WB   ? wb_value_in  :
                     src == FWD_OVR  ? ovr_value_q  : rf_value_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q        <= '0;
      ovr_valid_q <= 1'b0;
      ovr_value_q <= '0;
    end else begin
      rs_q        <= rs_d;
      ovr_valid_q <= ovr_valid_d;
      ovr_value_q <= ovr_value_d;
    end
  end
endmodule

// File: rtl/operand_bypass.sv
// operand_bypass: realigns rs1/rs2 with register file data, forwards in-flight results, flags load-use stalls
module operand_bypass
  import riscy_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  operand_bypass_if.slave   bus
);
  logic valid_q, valid_d;
  logic load_match1, load_match2, hazard;
  bypass_lane u_rs1 (
    .clk(clk), .rst_n(rst_n), .stall_in(bus.stall_in), .rs_in(bus.rs1_in),
    .rf_value_in(bus.rf_rs1_value_in), .mem_write_in(bus.mem_write_in), .mem_rd_in(bus.mem_rd_in),
    .mem_value_in(bus.mem_value_in), .mem_load_in(bus.mem_load_in), .wb_write_in(bus.wb_write_in),
    .wb_rd_in(bus.wb_rd_in), .wb_value_in(bus.wb_value_in), .value_out(bus.rs1_value_out),
    .load_match_out(load_match1)
  );
  bypass_lane u_rs2 (
    .clk(clk), .rst_n(rst_n), .stall_in(bus.stall_in), .rs_in(bus.rs2_in),
    .rf_value_in(bus.rf_rs2_value_in), .mem_write_in(bus.mem_write_in), .mem_rd_in(bus.mem_rd_in),
    .mem_value_in(bus.mem_value_in), .mem_load_in(bus.mem_load_in), .wb_write_in(bus.wb_write_in),
    .wb_rd_in(bus.wb_rd_in), .wb_value_in(bus.wb_value_in), .value_out(bus.rs2_value_out),
    .load_match_out(load_match2)
  );
  always_comb begin
    valid_d                = bus.stall_in ? valid_q : bus.id_valid_in;
    hazard                 = valid_q && !bus.mem_ready_in && (load_match1 || load_match2);
    bus.hazard_stall_out   = hazard;
    bus.operands_valid_out = valid_q && !hazard;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end
endmodule

// File: tb/tb_operand_bypass.sv
// tb_operand_bypass: directed scenarios plus random traffic against a WB-history reference model
module tb_operand_bypass;
  import riscy_pkg::*;
  typedef struct { int e; logic [REG_ADDR_W-1:0] a; logic [XLEN-1:0] v; } wb_ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  operand_bypass_if bus ();
  operand_bypass dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // model: operand value = live MEM/WB, else newest WB write seen since the operand was issued, else RF
  wb_ev_t                wb_log[$];
  logic [REG_ADDR_W-1:0] m_rs[2];
  int                    m_issue[2];
  bit                    m_valid;
  int                    edge_n = 0;
  function automatic logic [XLEN-1:0] exp_val(int i);
    logic [REG_ADDR_W-1:0] a;
    a = m_rs[i];
    if (a == 0) return '0;
    if (bus.mem_write_in && bus.mem_rd_in == a) return bus.mem_value_in;
    if (bus.wb_write_in && bus.wb_rd_in == a) return bus.wb_value_in;
    for (int k = wb_log.size() - 1; k >= 0 && wb_log[k].e >= m_issue[i]; k--)
      if (wb_log[k].a == a) return wb_log[k].v;
    return i == 0 ? bus.rf_rs1_value_in : bus.rf_rs2_value_in;
  endfunction
  function automatic bit exp_haz();
    return m_valid && bus.mem_write_in && bus.mem_load_in && !bus.mem_ready_in &&
           ((bus.mem_rd_in == m_rs[0] && m_rs[0] != 0) || (bus.mem_rd_in == m_rs[1] && m_rs[1] != 0));
  endfunction
  task automatic model_reset();
    m_rs[0] = '0; m_rs[1] = '0; m_valid = 0;
    m_issue[0] = edge_n; m_issue[1] = edge_n;
  endtask
  task automatic tick();
    if (!bus.stall_in) begin
      m_rs[0] = bus.rs1_in; m_rs[1] = bus.rs2_in;
      m_issue[0] = edge_n; m_issue[1] = edge_n;
      m_valid = bus.id_valid_in;
    end
    if (bus.wb_write_in) wb_log.push_back('{edge_n, bus.wb_rd_in, bus.wb_value_in});
    edge_n++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall_in = 0; bus.id_valid_in = 0; bus.rs1_in = '0; bus.rs2_in = '0;
    bus.rf_rs1_value_in = '0; bus.rf_rs2_value_in = '0;
    bus.mem_write_in = 0; bus.mem_rd_in = '0; bus.mem_value_in = '0; bus.mem_load_in = 0; bus.mem_ready_in = 1;
    bus.wb_write_in = 0; bus.wb_rd_in = '0; bus.wb_value_in = '0;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    vectors += 4;
    if (bus.rs1_value_out !== '0) begin miscompares++; $display("FAIL reset_rs1: got %h want 0", bus.rs1_value_out); end
    if (bus.rs2_value_out !== '0) begin miscompares++; $display("FAIL reset_rs2: got %h want 0", bus.rs2_value_out); end
    if (bus.operands_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.operands_valid_out); end
    if (bus.hazard_stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_hazard: got %b want 0", bus.hazard_stall_out); end
    rst_n = 1;
    model_reset();
    tick();
  endtask
  task automatic test_same_edge_wb();
    idle();
    bus.id_valid_in = 1; bus.rs1_in = 5; bus.rs2_in = 6;
    bus.wb_write_in = 1; bus.wb_rd_in = 5; bus.wb_value_in = 64'hAA;
    tick();
    bus.wb_write_in = 0; bus.rf_rs1_value_in = 64'h11; bus.id_valid_in = 0;
    #1;
    vectors += 2;
    if (bus.rs1_value_out !== 64'hAA) begin miscompares++; $display("FAIL same_edge_wb: got %h want aa", bus.rs1_value_out); end
    if (bus.operands_valid_out !== 1'b1) begin miscompares++; $display("FAIL same_edge_valid: got %b want 1", bus.operands_valid_out); end
    tick();
  endtask
  task automatic test_mem_priority();
    idle();
    bus.id_valid_in = 1; bus.rs1_in = 1; bus.rs2_in = 7;
    tick();
    bus.mem_write_in = 1; bus.mem_rd_in = 7; bus.mem_value_in = 64'h22;
    bus.wb_write_in = 1; bus.wb_rd_in = 7; bus.wb_value_in = 64'h33; bus.rf_rs2_value_in = 64'h77;
    bus.stall_in = 1;
    #1;
    vectors += 3;
    if (bus.rs2_value_out !== 64'h22) begin miscompares++; $display("FAIL mem_over_wb: got %h want 22", bus.rs2_value_out); end
    bus.mem_write_in = 0;
    #1;
    if (bus.rs2_value_out !== 64'h33) begin miscompares++; $display("FAIL wb_over_rf: got %h want 33", bus.rs2_value_out); end
    bus.wb_write_in = 0;
    #1;
    if (bus.rs2_value_out !== 64'h77) begin miscompares++; $display("FAIL rf_default: got %h want 77", bus.rs2_value_out); end
    tick();
  endtask
  task automatic test_stall_capture();
    idle();
    bus.id_valid_in = 1; bus.rs1_in = 3; bus.rf_rs1_value_in = 64'h99;
    tick();
    bus.stall_in = 1;
    tick();
    bus.wb_write_in = 1; bus.wb_rd_in = 3; bus.wb_value_in = 64'h44;
    #1;
    vectors += 4;
    if (bus.rs1_value_out !== 64'h44) begin miscompares++; $display("FAIL stall_wb_live: got %h want 44", bus.rs1_value_out); end
    tick();
    bus.wb_write_in = 0;
    #1;
    if (bus.rs1_value_out !== 64'h44) begin miscompares++; $display("FAIL stall_override: got %h want 44", bus.rs1_value_out); end
    tick();
    bus.stall_in = 0;
    #1;
    if (bus.rs1_value_out !== 64'h44) begin miscompares++; $display("FAIL override_held: got %h want 44", bus.rs1_value_out); end
    tick();
    if (bus.rs1_value_out !== 64'h99) begin miscompares++; $display("FAIL override_cleared: got %h want 99", bus.rs1_value_out); end
  endtask
  task automatic test_load_use();
    idle();
    bus.id_valid_in = 1; bus.rs1_in = 9; bus.rs2_in = 10;
    tick();
    bus.stall_in = 1; bus.mem_write_in = 1; bus.mem_rd_in = 9; bus.mem_load_in = 1; bus.mem_ready_in = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors += 2;
      if (bus.hazard_stall_out !== 1'b1) begin miscompares++; $display("FAIL load_use_hazard%0d: got %b want 1", c, bus.hazard_stall_out); end
      if (bus.operands_valid_out !== 1'b0) begin miscompares++; $display("FAIL load_use_valid%0d: got %b want 0", c, bus.operands_valid_out); end
      tick();
    end
    bus.mem_ready_in = 1; bus.mem_value_in = 64'h55; bus.stall_in = 0;
    #1;
    vectors += 3;
    if (bus.rs1_value_out !== 64'h55) begin miscompares++; $display("FAIL load_data: got %h want 55", bus.rs1_value_out); end
    if (bus.operands_valid_out !== 1'b1) begin miscompares++; $display("FAIL load_ready_valid: got %b want 1", bus.operands_valid_out); end
    if (bus.hazard_stall_out !== 1'b0) begin miscompares++; $display("FAIL load_ready_hazard: got %b want 0", bus.hazard_stall_out); end
    tick();
  endtask
  task automatic test_x0();
    idle();
    bus.id_valid_in = 1; bus.rf_rs1_value_in = 64'h12;
    bus.wb_write_in = 1; bus.wb_rd_in = 0; bus.wb_value_in = 64'hFF;
    tick();
    bus.wb_write_in = 0;
    #1;
    vectors += 2;
    if (bus.rs1_value_out !== '0) begin miscompares++; $display("FAIL x0_no_override: got %h want 0", bus.rs1_value_out); end
    bus.wb_write_in = 1; bus.mem_write_in = 1; bus.mem_rd_in = 0; bus.mem_value_in = 64'hEE;
    #1;
    if (bus.rs1_value_out !== '0) begin miscompares++; $display("FAIL x0_no_forward: got %h want 0", bus.rs1_value_out); end
    tick();
  endtask
  task automatic test_async_reset();
    idle();
    bus.id_valid_in = 1; bus.rs1_in = 4; bus.rs2_in = 8;
    bus.wb_write_in = 1; bus.wb_rd_in = 4; bus.wb_value_in = 64'h66;
    tick();
    bus.wb_write_in = 0; bus.stall_in = 1;
    #1;
    vectors += 6;
    if (bus.operands_valid_out !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid: got %b want 1", bus.operands_valid_out); end
    rst_n = 0;
    #1;
    if (bus.rs1_value_out !== '0) begin miscompares++; $display("FAIL async_rst_rs1: got %h want 0", bus.rs1_value_out); end
    if (bus.operands_valid_out !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid: got %b want 0", bus.operands_valid_out); end
    model_reset();
    rst_n = 1;
    tick();
    if (bus.operands_valid_out !== 1'b0) begin miscompares++; $display("FAIL post_rst_stalled_valid: got %b want 0", bus.operands_valid_out); end
    if (bus.rs1_value_out !== '0) begin miscompares++; $display("FAIL post_rst_override: got %h want 0", bus.rs1_value_out); end
    bus.stall_in = 0;
    tick();
    if (bus.operands_valid_out !== 1'b1) begin miscompares++; $display("FAIL post_rst_issue_valid: got %b want 1", bus.operands_valid_out); end
  endtask
  function automatic logic [REG_ADDR_W-1:0] rand_addr();
    return $urandom_range(15) == 0 ? REG_ADDR_W'($urandom) : REG_ADDR_W'($urandom_range(7));
  endfunction
  task automatic test_random();
    logic [XLEN-1:0] e1, e2;
    bit eh;
    for (int c = 0; c < 1500; c++) begin
      bus.stall_in = $urandom_range(3) == 0; bus.id_valid_in = $urandom_range(3) != 0;
      bus.rs1_in = rand_addr(); bus.rs2_in = rand_addr();
      bus.rf_rs1_value_in = {$urandom, $urandom}; bus.rf_rs2_value_in = {$urandom, $urandom};
      bus.mem_write_in = $urandom_range(1); bus.mem_rd_in = rand_addr(); bus.mem_value_in = {$urandom, $urandom};
      bus.mem_load_in = $urandom_range(1); bus.mem_ready_in = $urandom_range(1);
      bus.wb_write_in = $urandom_range(1); bus.wb_rd_in = rand_addr(); bus.wb_value_in = {$urandom, $urandom};
      #1;
      e1 = exp_val(0); e2 = exp_val(1); eh = exp_haz();
      vectors += 4;
      if (bus.rs1_value_out !== e1) begin miscompares++; $display("FAIL rand_rs1 c%0d: got %h want %h", c, bus.rs1_value_out, e1); end
      if (bus.rs2_value_out !== e2) begin miscompares++; $display("FAIL rand_rs2 c%0d: got %h want %h", c, bus.rs2_value_out, e2); end
      if (bus.hazard_stall_out !== eh) begin miscompares++; $display("FAIL rand_hazard c%0d: got %b want %b", c, bus.hazard_stall_out, eh); end
      if (bus.operands_valid_out !== (m_valid && !eh)) begin
        miscompares++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.operands_valid_out, m_valid && !eh);
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_same_edge_wb();
    test_mem_priority();
    test_stall_capture();
    test_load_use();
    test_x0();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
